// File: rtl/sid_filter_mc_if.sv
`timescale 1ns/1ps
// Signal bundle for sid_filter_mc: per-channel register images and sources
// packed channel-major (channel k at bits [W*k +: W]), plus the result and
// status outputs. The SID core side drives the master modport.
interface sid_filter_mc_if #(
  parameter int CHANNELS = 2,
  parameter int VW       = 22
);
  logic                   start;
  logic [CHANNELS-1:0]    mode;
  logic [16*CHANNELS-1:0] F0;
  logic [8*CHANNELS-1:0]  Res_Filt;
  logic [8*CHANNELS-1:0]  Mode_Vol;
  logic [VW*CHANNELS-1:0] voice1;
  logic [VW*CHANNELS-1:0] voice2;
  logic [VW*CHANNELS-1:0] voice3;
  logic [VW*CHANNELS-1:0] ext_in;
  logic [18*CHANNELS-1:0] audio;
  logic                   audio_valid;
  logic                   busy;
  logic                   overrun;

  modport master (
    output start, mode, F0, Res_Filt, Mode_Vol, voice1, voice2, voice3, ext_in,
    input  audio, audio_valid, busy, overrun
  );

  modport slave (
    input  start, mode, F0, Res_Filt, Mode_Vol, voice1, voice2, voice3, ext_in,
    output audio, audio_valid, busy, overrun
  );
endinterface

// File: rtl/sid_filter_mc.sv
`timescale 1ns/1ps
// sid_filter_mc: CHANNELS state-variable SID filters time-sharing a single
// signed 16x16 multiply-accumulate unit. A start strobe runs every channel
// through MUX -> LP -> BP -> HP -> VOL -> NEXT, one cycle per step.
// Optional build macro SID_FILTER_MIXER_DC_EN adds the 6581 mixer DC offset
// to the direct path of channels in 6581 mode.
module sid_filter_mc #(
  parameter int CHANNELS = 2,
  parameter int VW       = 22
) (
  input  logic           clk,
  input  logic           reset,
  sid_filter_mc_if.slave bus
);

  // Sources are scaled down to the 16-bit filter domain by this shift.
  localparam int SH = VW - 15;
  // Sum of four sources plus the DC term needs three extra bits.
  localparam int SW = VW + 3;
  localparam logic [1:0] LAST_CH = 2'(CHANNELS - 1);

  typedef enum logic [2:0] {IDLE, MUX, LP, BP, HP, VOL, NEXT} state_t;

  // Saturate a wide signed value to the 16-bit filter range.
  function automatic logic signed [15:0] clamp16(input logic signed [19:0] x);
    if (x > 20'sd32767)
      return 16'sh7FFF;
    else if (x < -20'sd32768)
      return 16'sh8000;
    else
      return x[15:0];
  endfunction

  // 1024/Q by {mode, resonance}: 6581 uses 1/(0.707 + res/8),
  // 8580 uses 2^((4 - res)/8).
  function automatic logic signed [15:0] q_inv(input logic [4:0] idx);
    case (idx)
      5'd0:    return 16'sd1448;
      5'd1:    return 16'sd1231;
      5'd2:    return 16'sd1070;
      5'd3:    return 16'sd946;
      5'd4:    return 16'sd848;
      5'd5:    return 16'sd769;
      5'd6:    return 16'sd703;
      5'd7:    return 16'sd647;
      5'd8:    return 16'sd600;
      5'd9:    return 16'sd559;
      5'd10:   return 16'sd523;
      5'd11:   return 16'sd492;
      5'd12:   return 16'sd464;
      5'd13:   return 16'sd439;
      5'd14:   return 16'sd417;
      5'd15:   return 16'sd397;
      5'd16:   return 16'sd1448;
      5'd17:   return 16'sd1328;
      5'd18:   return 16'sd1218;
      5'd19:   return 16'sd1117;
      5'd20:   return 16'sd1024;
      5'd21:   return 16'sd939;
      5'd22:   return 16'sd861;
      5'd23:   return 16'sd790;
      5'd24:   return 16'sd724;
      5'd25:   return 16'sd664;
      5'd26:   return 16'sd609;
      5'd27:   return 16'sd558;
      5'd28:   return 16'sd512;
      5'd29:   return 16'sd470;
      5'd30:   return 16'sd431;
      default: return 16'sd395;
    endcase
  endfunction

  state_t state, state_nx;
  logic [1:0] ch;

  // Per-channel views of the packed buses; slots beyond CHANNELS read as 0
  // so a 2-bit channel index can address them without width games.
  logic                 mode_c [4];
  logic [15:0]          f0_c   [4];
  logic [7:0]           rf_c   [4];
  logic [7:0]           mv_c   [4];
  logic signed [VW-1:0] v1_c   [4];
  logic signed [VW-1:0] v2_c   [4];
  logic signed [VW-1:0] v3_c   [4];
  logic signed [VW-1:0] ext_c  [4];
  logic [17:0]          audio_r [4];

  for (genvar k = 0; k < 4; k++) begin : g_ch
    if (k < CHANNELS) begin : g_used
      assign mode_c[k] = bus.mode[k];
      assign f0_c[k]   = bus.F0[16*k +: 16];
      assign rf_c[k]   = bus.Res_Filt[8*k +: 8];
      assign mv_c[k]   = bus.Mode_Vol[8*k +: 8];
      assign v1_c[k]   = bus.voice1[VW*k +: VW];
      assign v2_c[k]   = bus.voice2[VW*k +: VW];
      assign v3_c[k]   = bus.voice3[VW*k +: VW];
      assign ext_c[k]  = bus.ext_in[VW*k +: VW];
      assign bus.audio[18*k +: 18] = audio_r[k];
    end else begin : g_unused
      assign mode_c[k] = 1'b0;
      assign f0_c[k]   = '0;
      assign rf_c[k]   = '0;
      assign mv_c[k]   = '0;
      assign v1_c[k]   = '0;
      assign v2_c[k]   = '0;
      assign v3_c[k]   = '0;
      assign ext_c[k]  = '0;
    end
  end

  // Filter state per channel, plus operands latched for the current channel.
  logic signed [15:0] vlp_r [4];
  logic signed [15:0] vbp_r [4];
  logic signed [15:0] vhp_r [4];
  logic signed [16:0] vi;
  logic signed [17:0] vd;
  logic signed [15:0] f0_p0;
  logic signed [15:0] q_p0;
  logic signed [15:0] vol_b_p0;
  logic [3:0]         vol_a_p0;
  logic               vld_p0;
  logic               overrun_r;

  assign bus.busy        = (state != IDLE);
  assign bus.audio_valid = vld_p0;
  assign bus.overrun     = overrun_r;

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Sequencer next state: fixed one-cycle steps, channels visited in order.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = MUX;
      MUX:     state_nx = LP;
      LP:      state_nx = BP;
      BP:      state_nx = HP;
      HP:      state_nx = VOL;
      VOL:     state_nx = NEXT;
      NEXT:    state_nx = (ch == LAST_CH) ? IDLE : MUX;
      default: state_nx = IDLE;
    endcase
  end

  // Source routing: filter bits pick the filter input, the rest go direct
  // (voice3 can be muted from the direct path by the 3OFF bit).
  logic signed [SW-1:0] sum_f, sum_d;
  always_comb begin
    sum_f = '0;
    sum_d = '0;
    if (rf_c[ch][0]) sum_f = sum_f + SW'(v1_c[ch]);
    else             sum_d = sum_d + SW'(v1_c[ch]);
    if (rf_c[ch][1]) sum_f = sum_f + SW'(v2_c[ch]);
    else             sum_d = sum_d + SW'(v2_c[ch]);
    if (rf_c[ch][2]) sum_f = sum_f + SW'(v3_c[ch]);
    else if (!mv_c[ch][7]) sum_d = sum_d + SW'(v3_c[ch]);
    if (rf_c[ch][3]) sum_f = sum_f + SW'(ext_c[ch]);
    else             sum_d = sum_d + SW'(ext_c[ch]);
`ifdef SID_FILTER_MIXER_DC_EN
    if (!mode_c[ch]) sum_d = sum_d - SW'(58254);
`endif
  end

  // Output mix: direct path plus the selected filter taps.
  logic signed [19:0] vol_sum;
  always_comb begin
    vol_sum = 20'(vd);
    if (mv_c[ch][4]) vol_sum = vol_sum + 20'(vlp_r[ch]);
    if (mv_c[ch][5]) vol_sum = vol_sum + 20'(vbp_r[ch]);
    if (mv_c[ch][6]) vol_sum = vol_sum + 20'(vhp_r[ch]);
  end

  // Shared multiply-accumulate: operands steered by the sequencer step.
  logic signed [15:0] mul_a, mul_b;
  logic signed [31:0] mul_c, prod, mul_o;
  logic               mul_sub;
  always_comb begin
    mul_a   = '0;
    mul_b   = '0;
    mul_c   = '0;
    mul_sub = 1'b0;
    case (state)
      LP: begin
        mul_a   = signed'(f0_c[ch]);
        mul_b   = vbp_r[ch];
        mul_sub = 1'b1;
      end
      BP: begin
        mul_a   = f0_p0;
        mul_b   = vhp_r[ch];
        mul_sub = 1'b1;
      end
      HP: begin
        mul_a = q_p0;
        mul_b = vbp_r[ch];
        mul_c = -((32'(vlp_r[ch]) + 32'(vi)) <<< 10);
      end
      NEXT: begin
        mul_a = signed'({12'd0, vol_a_p0});
        mul_b = vol_b_p0;
      end
      default: ;
    endcase
    prod  = 32'(mul_a) * 32'(mul_b);
    mul_o = mul_sub ? (mul_c - prod) : (mul_c + prod);
  end

  // Datapath and status registers, advanced by the sequencer step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch        <= '0;
      vi        <= '0;
      vd        <= '0;
      f0_p0     <= '0;
      q_p0      <= '0;
      vol_a_p0  <= '0;
      vol_b_p0  <= '0;
      vld_p0    <= 1'b0;
      overrun_r <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        vlp_r[k]   <= '0;
        vbp_r[k]   <= '0;
        vhp_r[k]   <= '0;
        audio_r[k] <= '0;
      end
    end else begin
      vld_p0 <= 1'b0;
      if (bus.start && (state != IDLE))
        overrun_r <= 1'b1;
      case (state)
        IDLE: ch <= '0;
        // MUX: scale sources and fetch this channel's damping factor.
        MUX: begin
          vi   <= 17'(sum_f >>> SH);
          vd   <= 18'(sum_d >>> SH);
          q_p0 <= q_inv({mode_c[ch], rf_c[ch][7:4]});
        end
        // LP: integrate band-pass into low-pass; keep F0 for the BP step.
        LP: begin
          vlp_r[ch] <= clamp16(20'(vlp_r[ch]) + 20'(mul_o >>> 17));
          f0_p0     <= signed'(f0_c[ch]);
        end
        // BP: integrate high-pass into band-pass.
        BP: vbp_r[ch] <= clamp16(20'(vbp_r[ch]) + 20'(mul_o >>> 17));
        // HP: high-pass from the fresh low-pass and band-pass values.
        HP: vhp_r[ch] <= clamp16(20'(signed'(mul_o[26:10])));
        // VOL: register mix and volume so the multiply runs next cycle.
        VOL: begin
          vol_b_p0 <= clamp16(vol_sum);
          vol_a_p0 <= mv_c[ch][3:0];
        end
        // NEXT: scaled output lands in this channel's audio slot.
        NEXT: begin
          audio_r[ch] <= mul_o[19:2];
          if (ch == LAST_CH)
            vld_p0 <= 1'b1;
          else
            ch <= ch + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
